chamber_chain_seq: RTL and testbench

Parametrised, clocked sequencer for a linear chain of DEPTH microfluidic chambers joined by DEPTH+1 valves. Valve 0 is the inlet and valve DEPTH is the outlet.
- Accepts tagged fluid plugs at the inlet through a valid/ready handshake.
- Holds each plug in each chamber for a programmable dwell time.
- Advances plugs chamber to chamber whenever the next chamber is free.
- Presents plugs at the outlet through a valid/ready handshake.
- Drives the valve-control bus for the chip.

---
 rtl/chamber_chain_pkg.sv | 34 +++
 rtl/chamber_slot.sv | 136 +++++++++++++
 rtl/chamber_chain_seq.sv | 155 +++++++++++++++
 tb/tb_chamber_chain_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chamber_chain_pkg.sv
// Shared types and width helpers for the chamber chain sequencer.
//   chamber_state_e : per-chamber state (EMPTY, FILL, DWELL, READY, MOVING)
//   val_width()     : bits needed to hold a value
//   idx_width()     : bits needed to index n items
//   max3()          : largest of three counts, used to size the chamber counter
package chamber_chain_pkg;

   typedef enum logic [2:0] {
      CH_EMPTY  = 3'd0,
      CH_FILL   = 3'd1,
      CH_DWELL  = 3'd2,
      CH_READY  = 3'd3,
      CH_MOVING = 3'd4
   } chamber_state_e;

   // Bits needed to represent max_val (never less than 1).
   function automatic int unsigned val_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   // Bits needed to index n items (never less than 1).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/chamber_slot.sv
// One microfluidic chamber: state, held tag, shared dwell/transfer/watchdog counter.
// Optional watchdog enabled by CHAMBER_CHAIN_STALL_WATCHDOG_EN.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   fill_req       : inlet handshake into this chamber (head chamber only)
//   load_req       : upstream move into this chamber completes this edge
//   tag_in         : tag accompanying fill_req / load_req
//   dn_free        : downstream can take this chamber's plug at this edge
//   flush          : cut any dwell short
//   state_o, tag_o : registered chamber state and tag
//   fill_valve_c   : upstream valve of this chamber is open (inlet fill)
//   move_valve_c   : downstream valve of this chamber is open (move out)
//   move_done_c    : last cycle of the move out
//   stall_hit_c    : READY long enough to trip the watchdog
module chamber_slot
   import chamber_chain_pkg::*;
#(
   parameter int unsigned TAG_W        = 4,
   parameter int unsigned DWELL_CYC    = 4,
   parameter int unsigned TRANSFER_CYC = 2,
   parameter int unsigned STALL_LIMIT  = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fill_req,
   input  logic             load_req,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             dn_free,
   input  logic             flush,
   output chamber_state_e   state_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             fill_valve_c,
   output logic             move_valve_c,
   output logic             move_done_c,
   output logic             stall_hit_c
);

   localparam int unsigned CNT_W = val_width(max3(DWELL_CYC, TRANSFER_CYC, STALL_LIMIT));
   localparam logic [CNT_W-1:0] XFER_LOAD  = CNT_W'(TRANSFER_CYC - 1);
   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'((DWELL_CYC == 0) ? 0 : DWELL_CYC - 1);
   // A plug arriving in a chamber skips DWELL entirely when there is no dwell time.
   localparam chamber_state_e HOLD_ST = (DWELL_CYC == 0) ? CH_READY : CH_DWELL;
`ifdef CHAMBER_CHAIN_STALL_WATCHDOG_EN
   localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);
`endif

   chamber_state_e   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   // State register; reset drops the plug and closes its valves at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CH_EMPTY;
         cnt_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
      end
   end

   // Next state. The counter times FILL/MOVING/DWELL and, while READY, the stall.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tag_d   = tag_q;
      unique case (state_q)
         CH_EMPTY: begin
            if (fill_req) begin
               state_d = CH_FILL;
               cnt_d   = XFER_LOAD;
               tag_d   = tag_in;
            end else if (load_req) begin
               state_d = HOLD_ST;
               cnt_d   = DWELL_LOAD;
               tag_d   = tag_in;
            end
         end
         CH_FILL: begin
            if (cnt_q == '0) begin
               state_d = HOLD_ST;
               cnt_d   = DWELL_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         CH_DWELL: begin
            if (flush || (cnt_q == '0)) begin
               state_d = CH_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         CH_READY: begin
            if (dn_free) begin
               state_d = CH_MOVING;
               cnt_d   = XFER_LOAD;
            end
`ifdef CHAMBER_CHAIN_STALL_WATCHDOG_EN
            else if (cnt_q != STALL_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         CH_MOVING: begin
            if (cnt_q == '0) begin
               state_d = CH_EMPTY;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = CH_EMPTY;
            cnt_d   = '0;
         end
      endcase
   end

   // Decoded outputs of the chamber state.
   always_comb begin
      fill_valve_c = (state_q == CH_FILL);
      move_valve_c = (state_q == CH_MOVING);
      move_done_c  = (state_q == CH_MOVING) && (cnt_q == '0);
      stall_hit_c  = 1'b0;
`ifdef CHAMBER_CHAIN_STALL_WATCHDOG_EN
      stall_hit_c  = (state_q == CH_READY) && (cnt_q == STALL_LAST);
`endif
   end

   assign state_o = state_q;
   assign tag_o   = tag_q;

endmodule

// File: rtl/chamber_chain_seq.sv
// Sequencer for a linear chain of DEPTH chambers joined by DEPTH+1 valves.
// Valve 0 is the inlet, valve DEPTH the outlet. Optional stall watchdog is
// enabled by defining CHAMBER_CHAIN_STALL_WATCHDOG_EN.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready/in_tag   : inlet plug handshake
//   out_valid/out_ready/out_tag: outlet plug handshake
//   flush                      : end dwells early and block the inlet
//   valve_open                 : valve actuation, bit i between chamber i-1 and i
//   occupancy, busy            : count of non-empty chambers, and its non-zero flag
//   stall_err, stall_idx       : sticky watchdog flag and first offending chamber
module chamber_chain_seq
   import chamber_chain_pkg::*;
#(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned TAG_W        = 4,
   parameter int unsigned DWELL_CYC    = 4,
   parameter int unsigned TRANSFER_CYC = 2,
   parameter int unsigned STALL_LIMIT  = 255
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [TAG_W-1:0]             in_tag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [TAG_W-1:0]             out_tag,
   input  logic                         flush,
   output logic [DEPTH:0]               valve_open,
   output logic [val_width(DEPTH)-1:0]  occupancy,
   output logic                         busy,
   output logic                         stall_err,
   output logic [idx_width(DEPTH)-1:0]  stall_idx
);

   localparam int unsigned OCC_W = val_width(DEPTH);
   localparam int unsigned IDX_W = idx_width(DEPTH);

   chamber_state_e   st [DEPTH];
   logic [TAG_W-1:0] tg [DEPTH];
   logic [DEPTH-1:0] fill_v;
   logic [DEPTH-1:0] move_v;
   logic [DEPTH-1:0] done;
   logic [DEPTH-1:0] hit;
   logic             in_hs;

   assign in_ready  = (st[0] == CH_EMPTY) && !flush;
   assign in_hs     = in_valid && in_ready;
   assign out_valid = (st[DEPTH-1] == CH_READY);
   assign out_tag   = tg[DEPTH-1];

   // Chamber i hands its plug to i+1; the head is fed by the inlet, the tail drains to the outlet.
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic             fill_req;
      logic             load_req;
      logic             dn_free;
      logic [TAG_W-1:0] tag_in;

      if (i == 0) begin : g_head
         assign fill_req = in_hs;
         assign load_req = 1'b0;
         assign tag_in   = in_tag;
      end else begin : g_body
         assign fill_req = 1'b0;
         assign load_req = done[i-1];
         assign tag_in   = tg[i-1];
      end

      // A chamber being filled by its upstream neighbour is still EMPTY, but
      // that neighbour is MOVING rather than READY, so it cannot be claimed twice.
      if (i == DEPTH-1) begin : g_tail
         assign dn_free = out_ready;
      end else begin : g_mid
         assign dn_free = (st[i+1] == CH_EMPTY);
      end

      chamber_slot #(
         .TAG_W        (TAG_W),
         .DWELL_CYC    (DWELL_CYC),
         .TRANSFER_CYC (TRANSFER_CYC),
         .STALL_LIMIT  (STALL_LIMIT)
      ) u_slot (
         .clk          (clk),
         .rst_n        (rst_n),
         .fill_req     (fill_req),
         .load_req     (load_req),
         .tag_in       (tag_in),
         .dn_free      (dn_free),
         .flush        (flush),
         .state_o      (st[i]),
         .tag_o        (tg[i]),
         .fill_valve_c (fill_v[i]),
         .move_valve_c (move_v[i]),
         .move_done_c  (done[i]),
         .stall_hit_c  (hit[i])
      );
   end

   // The tail's move completion has no downstream chamber to load.
   logic unused_done;
   assign unused_done = done[DEPTH-1];

   // Valve i is opened by chamber i filling or by chamber i-1 moving out.
   assign valve_open = {move_v, 1'b0} | {1'b0, fill_v};

   // Popcount of non-empty chambers.
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (st[i] != CH_EMPTY) occupancy = occupancy + OCC_W'(1);
      end
   end

   assign busy = (occupancy != '0);

`ifdef CHAMBER_CHAIN_STALL_WATCHDOG_EN
   logic             stall_err_q, stall_err_d;
   logic [IDX_W-1:0] stall_idx_q, stall_idx_d;

   // First trip wins; descending scan leaves the lowest tripping index.
   always_comb begin
      stall_err_d = stall_err_q;
      stall_idx_d = stall_idx_q;
      if (!stall_err_q) begin
         for (int i = DEPTH-1; i >= 0; i--) begin
            if (hit[i]) begin
               stall_err_d = 1'b1;
               stall_idx_d = IDX_W'(i);
            end
         end
      end
   end

   // Sticky watchdog status, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_err_q <= 1'b0;
         stall_idx_q <= '0;
      end else begin
         stall_err_q <= stall_err_d;
         stall_idx_q <= stall_idx_d;
      end
   end

   assign stall_err = stall_err_q;
   assign stall_idx = stall_idx_q;
`else
   logic unused_hit;
   assign unused_hit = |hit;
   assign stall_err  = 1'b0;
   assign stall_idx  = '0;
`endif

endmodule

// File: tb/tb_chamber_chain_seq.sv
// Self-checking bench for chamber_chain_seq with DEPTH=4, DWELL_CYC=3, TRANSFER_CYC=2.
module tb_chamber_chain_seq;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TAG_W = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [TAG_W-1:0] out_tag;
   logic             flush;
   logic [DEPTH:0]   valve_open;
   logic [2:0]       occupancy;
   logic             busy;
   logic             stall_err;
   logic [1:0]       stall_idx;

   chamber_chain_seq #(
      .DEPTH        (DEPTH),
      .TAG_W        (TAG_W),
      .DWELL_CYC    (3),
      .TRANSFER_CYC (2),
      .STALL_LIMIT  (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_tag    (out_tag),
      .flush      (flush),
      .valve_open (valve_open),
      .occupancy  (occupancy),
      .busy       (busy),
      .stall_err  (stall_err),
      .stall_idx  (stall_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;
   logic [TAG_W-1:0] sb [$];

   typedef struct {
      logic [TAG_W-1:0] tag;
      int               ready_delay;
      int               exp_valid_lat;
      int               exp_empty_lat;
   } vec_t;
   vec_t vecs [4];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one plug; returns in the cycle after the inlet handshake.
   task automatic send(input logic [TAG_W-1:0] t);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin step(); n++; end
      chk("send_ready", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_tag   = t;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (occupancy != 0 && n < 300) begin step(); n++; end
      chk(name, 32'(occupancy), 0);
   endtask

   // Scoreboard: tags pushed at inlet handshake, popped and compared at outlet handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) sb.push_back(in_tag);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errs++;
               $display("FAIL sb_underflow: got tag %0d with none expected", out_tag);
            end else begin
               logic [TAG_W-1:0] e;
               e = sb.pop_front();
               chk("sb_tag", 32'(out_tag), 32'(e));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      int k;
      int acc;
      logic [TAG_W-1:0] t;
      logic hs;
      logic [DEPTH:0] ev;

      vecs[0] = '{4'h5, 0, 24, 27};
      vecs[1] = '{4'hA, 2, 24, 29};
      vecs[2] = '{4'hF, 5, 24, 32};
      vecs[3] = '{4'h0, 1, 24, 28};

      rst_n = 1'b0; in_valid = 1'b0; in_tag = '0; out_ready = 1'b0; flush = 1'b0;
      step(); step();
      chk("rst_valve", 32'(valve_open), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_occ", 32'(occupancy), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_stall_err", 32'(stall_err), 0);
      chk("rst_stall_idx", 32'(stall_idx), 0);
      rst_n = 1'b1;
      step();
      chk("rel_in_ready", 32'(in_ready), 1);

      // Single plug, tag 5: valve k opens at 6k+1..6k+2 after the handshake.
      out_ready = 1'b1;
      send(4'd5);
      for (int c = 1; c <= 28; c++) begin
         ev = '0;
         for (int s = 0; s <= int'(DEPTH); s++)
            if (c == 6*s + 1 || c == 6*s + 2) ev[s] = 1'b1;
         chk("s2_valve", 32'(valve_open), 32'(ev));
         chk("s2_out_valid", 32'(out_valid), 32'(c == 24));
         if (c == 24) chk("s2_out_tag", 32'(out_tag), 5);
         chk("s2_occ", 32'(occupancy), (c <= 26) ? 1 : 0);
         chk("s2_busy", 32'(busy), (c <= 26) ? 1 : 0);
         step();
      end

      // Table: outlet latency and stable hold under varying backpressure.
      for (int v = 0; v < 4; v++) begin
         out_ready = (vecs[v].ready_delay == 0);
         send(vecs[v].tag);
         k = 1;
         while (!out_valid && k < 100) begin step(); k++; end
         chk("tbl_valid_lat", k, vecs[v].exp_valid_lat);
         for (int d = 0; d < vecs[v].ready_delay; d++) begin
            chk("tbl_hold_valid", 32'(out_valid), 1);
            chk("tbl_hold_tag", 32'(out_tag), 32'(vecs[v].tag));
            step(); k++;
         end
         out_ready = 1'b1;
         while (occupancy != 0 && k < 200) begin step(); k++; end
         chk("tbl_empty_lat", k, vecs[v].exp_empty_lat);
      end

      // Flush: a dwelling plug with 3 cycles left becomes READY on the next edge.
      send(4'd7);
      step(); step();
      chk("s4_dwell_closed", 32'(valve_open), 0);
      flush = 1'b1;
      #1;
      chk("s4_in_ready_flush", 32'(in_ready), 0);
      step();
      flush = 1'b0;
      chk("s4_ready_closed", 32'(valve_open), 0);
      step();
      chk("s4_early_move", 32'(valve_open), 32'(5'b00010));
      step(); step();
      chk("s4_head_empty", 32'(in_ready), 1);
      flush = 1'b1;
      #1;
      chk("s4_flush_blocks", 32'(in_ready), 0);
      flush = 1'b0;
      #1;
      chk("s4_unflush", 32'(in_ready), 1);
      wait_empty("s4_drain");

      // Concurrency: chambers 0 and 2 READY together with 1 and 3 free.
      send(4'h3);
      for (int n = 1; n < 12; n++) step();
      send(4'hC);
      for (int n = 0; n < 5; n++) step();
      chk("s5_pre", 32'(valve_open), 0);
      step();
      chk("s5_par0", 32'(valve_open), 32'(5'b01010));
      step();
      chk("s5_par1", 32'(valve_open), 32'(5'b01010));
      step();
      chk("s5_post", 32'(valve_open), 0);
      wait_empty("s5_drain");

      // Backpressure: tags 1..5 offered, four fit.
      out_ready = 1'b0;
      t = 4'd1; acc = 0;
      in_valid = 1'b1; in_tag = t;
      for (int n = 0; n < 120; n++) begin
         hs = in_ready;
         step();
         if (hs) begin acc++; t = t + 4'd1; in_tag = t; end
      end
      chk("s3_accepted", acc, 4);
      chk("s3_in_ready", 32'(in_ready), 0);
      chk("s3_occ", 32'(occupancy), 4);
      for (int n = 0; n < 4; n++) begin
         chk("s3_hold_valid", 32'(out_valid), 1);
         chk("s3_hold_tag", 32'(out_tag), 1);
         step();
      end
`ifndef CHAMBER_CHAIN_STALL_WATCHDOG_EN
      chk("s3_stall_tied", 32'(stall_err), 0);
`endif
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_empty("s3_drain");
      chk("s3_sb_empty", sb.size(), 0);

      // Reset mid-transfer: valves close immediately, plug dropped.
      send(4'd9);
      chk("s1_fill_open", 32'(valve_open), 1);
      rst_n = 1'b0;
      #1;
      chk("s1_async_valve", 32'(valve_open), 0);
      chk("s1_async_occ", 32'(occupancy), 0);
      chk("s1_async_out_valid", 32'(out_valid), 0);
      sb.delete();
      step();
      rst_n = 1'b1;
      step();
      chk("s1_in_ready", 32'(in_ready), 1);
      chk("s1_busy", 32'(busy), 0);
      for (int n = 0; n < 30; n++) begin
         chk("s1_dropped", 32'(occupancy), 0);
         step();
      end

`ifdef CHAMBER_CHAIN_STALL_WATCHDOG_EN
      // Watchdog: outlet plug READY for 10 cycles trips chamber 3.
      out_ready = 1'b0;
      send(4'd6);
      k = 1;
      while (!out_valid && k < 100) begin step(); k++; end
      chk("s6_valid_lat", k, 24);
      for (int n = 0; n < 9; n++) step();
      chk("s6_not_yet", 32'(stall_err), 0);
      step();
      chk("s6_err", 32'(stall_err), 1);
      chk("s6_idx", 32'(stall_idx), 3);
      out_ready = 1'b1;
      wait_empty("s6_drain");
      chk("s6_sticky", 32'(stall_err), 1);
      rst_n = 1'b0;
      #1;
      chk("s6_cleared", 32'(stall_err), 0);
      sb.delete();
      step();
      rst_n = 1'b1;
      step();
`endif

      chk("end_sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
